// File: rtl/sha256_w_sched_ctrl.sv
// sha256_w_sched_ctrl
//   Message-schedule sequencer for SHA-256. It accepts one 512-bit block over a
//   valid/ready handshake and keeps a 16-word sliding window. It streams
//   W[0..ROUNDS-1] to the compression core, one word per handshake. Each accepted
//   word shifts the window and appends the next expanded word.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   start_valid_i  block_in_i is valid
//   start_ready_o  controller idle and able to accept a block
//   block_in_i     message block, W0 = [511:480] ... W15 = [31:0]
//   abort_i        synchronous cancel of the block in flight
//   w_valid_o      w_out_o / w_idx_o / w_last_o are valid
//   w_ready_i      consumer accepts the current word
//   w_out_o        schedule word W[w_idx_o]
//   w_idx_o        round index of w_out_o
//   w_last_o       marks w_idx_o == ROUNDS-1
//   busy_o         a block is in flight
//   done_o         one-cycle pulse after the last word handshake
module sha256_w_sched_ctrl #(
    parameter int ROUNDS = 64,   // legal 16..64
    parameter int IDX_W  = 6     // 2**IDX_W >= ROUNDS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [511:0]     block_in_i,
    input  logic             abort_i,
    output logic             w_valid_o,
    input  logic             w_ready_i,
    output logic [31:0]      w_out_o,
    output logic [IDX_W-1:0] w_idx_o,
    output logic             w_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0]       ST_IDLE = 2'b00;
    localparam logic [1:0]       ST_RUN  = 2'b01;
    localparam logic [IDX_W-1:0] T_LAST  = IDX_W'(ROUNDS - 1);

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic [1:0]             state_q, state_d;
    logic [15:0][31:0]      win_q, win_d;
    logic [IDX_W-1:0]       t_q, t_d;
    logic                   rdy_q;
    logic                   last_q;
    logic                   done_q, done_d;
    logic [31:0]            nw;

    // win_q[0] is always the word currently presented. The expansion reads the
    // same taps as W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign nw = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort_i is ignored here; a start handshake always wins.
                if (start_valid_i && rdy_q) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block_in_i[511-32*i -: 32];
                    end
                    t_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort beats a same-cycle handshake and leaves the window alone.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (w_ready_i) begin
                    if (t_q == T_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[15] = nw;
                        t_d       = t_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            t_q     <= '0;
            rdy_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
            // Registered so start_ready stays low through reset and never
            // depends on a same-cycle input.
            rdy_q   <= (state_d == ST_IDLE);
            last_q  <= (state_d == ST_RUN) && (t_d == T_LAST);
            done_q  <= done_d;
        end
    end

    assign start_ready_o = rdy_q;
    assign w_valid_o     = (state_q == ST_RUN);
    assign w_out_o       = win_q[0];
    assign w_idx_o       = t_q;
    assign w_last_o      = last_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
module tb_sha256_w_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid, start_valid16;
    logic [511:0] blk, blk16;
    logic         abort, w_ready;
    logic         start_ready, w_valid, w_last, busy, done;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         sr16, wv16, wl16, busy16, done16;
    logic [31:0]  wo16;
    logic [3:0]   wi16;

    int total = 0;
    int bad   = 0;
    logic [31:0] mw  [64];
    logic [31:0] cap [64];

    always #5 clk = ~clk;

    sha256_w_sched_ctrl #(.ROUNDS(64), .IDX_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .start_valid_i(start_valid), .start_ready_o(start_ready),
        .block_in_i(blk), .abort_i(abort), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .w_out_o(w_out), .w_idx_o(w_idx), .w_last_o(w_last), .busy_o(busy), .done_o(done)
    );

    sha256_w_sched_ctrl #(.ROUNDS(16), .IDX_W(4)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_valid_i(start_valid16), .start_ready_o(sr16),
        .block_in_i(blk16), .abort_i(abort), .w_valid_o(wv16), .w_ready_i(w_ready),
        .w_out_o(wo16), .w_idx_o(wi16), .w_last_o(wl16), .busy_o(busy16), .done_o(done16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    // Reference schedule from the textbook recurrence over the full array.
    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            mw[t] = ms1(mw[t-2]) + mw[t-7] + ms0(mw[t-15]) + mw[t-16];
    endtask

    function automatic logic [511:0] rnd_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Expects the first word on display; w_ready must be 1. Ends in the done cycle.
    task automatic stream(input int n);
        for (int t = 0; t < n; t++) begin
            chk("w_valid", {31'd0, w_valid}, 32'd1);
            chk("w_out", w_out, mw[t]);
            chk("w_idx", {26'd0, w_idx}, t);
            chk("w_last", {31'd0, w_last}, {31'd0, t == n-1});
            cap[t] = w_out;
            step();
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("w_valid_end", {31'd0, w_valid}, 32'd0);
        chk("start_ready_done", {31'd0, start_ready}, 32'd1);
    endtask

    initial begin
        int hs, cyc;
        logic rdy;
        logic [511:0] b_next;

        rst = 1'b1; start_valid = 1'b0; start_valid16 = 1'b0;
        blk = '0; blk16 = '0; abort = 1'b0; w_ready = 1'b0;
        step(); step();

        // Reset values
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_w_idx", {26'd0, w_idx}, 32'd0);
        chk("rst_w_last", {31'd0, w_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_start_ready", {31'd0, start_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, start_ready}, 32'd1);
        chk("post_rst_ready16", {31'd0, sr16}, 32'd1);

        // T1: "abc" block, w_ready tied high
        blk = '0;
        blk[511:480] = 32'h61626380;
        blk[31:0]    = 32'h00000018;
        build_model(blk);
        w_ready = 1'b1; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready_low", {31'd0, start_ready}, 32'd0);
        stream(64);
        chk("abc_w0", cap[0], 32'h61626380);
        chk("abc_w15", cap[15], 32'h00000018);
        chk("abc_w16", cap[16], 32'h61626380);
        chk("abc_w17", cap[17], 32'h000F0000);
        step();
        chk("t1_done_once", {31'd0, done}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // T2: random block with random backpressure
        blk = rnd_block();
        build_model(blk);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 64 && cyc < 2000) begin
            chk("t2_valid", {31'd0, w_valid}, 32'd1);
            chk("t2_w_out", w_out, mw[hs]);
            chk("t2_w_idx", {26'd0, w_idx}, hs);
            chk("t2_w_last", {31'd0, w_last}, {31'd0, hs == 63});
            chk("t2_no_early_done", {31'd0, done}, 32'd0);
            rdy = 1'($urandom_range(0, 1));
            w_ready = rdy;
            step();
            if (rdy) hs++;
            cyc++;
        end
        chk("t2_handshakes", hs, 32'd64);
        chk("t2_done", {31'd0, done}, 32'd1);
        w_ready = 1'b1;
        step();
        chk("t2_done_once", {31'd0, done}, 32'd0);

        // T3: abort at t=20 while stalled
        blk = rnd_block();
        build_model(blk);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        w_ready = 1'b0;
        chk("t3_idx20", {26'd0, w_idx}, 32'd20);
        chk("t3_w20", w_out, mw[20]);
        step();
        chk("t3_hold_idx", {26'd0, w_idx}, 32'd20);
        chk("t3_hold_w", w_out, mw[20]);
        abort = 1'b1; w_ready = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_valid_drop", {31'd0, w_valid}, 32'd0);
        chk("t3_no_done", {31'd0, done}, 32'd0);
        chk("t3_ready", {31'd0, start_ready}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t3_no_done_late", {31'd0, done}, 32'd0);
        blk = rnd_block();
        build_model(blk);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        stream(64);
        step();

        // T4: back-to-back blocks with start_valid held high
        blk = rnd_block();
        b_next = rnd_block();
        build_model(blk);
        start_valid = 1'b1;
        step();
        blk = b_next;
        stream(64);
        build_model(b_next);
        step();
        start_valid = 1'b0;
        chk("t4_second_valid", {31'd0, w_valid}, 32'd1);
        chk("t4_idx_restart", {26'd0, w_idx}, 32'd0);
        stream(64);
        step();
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // T5: reset mid-block at t=33
        blk = rnd_block();
        build_model(blk);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 33; i++) step();
        chk("t5_idx33", {26'd0, w_idx}, 32'd33);
        chk("t5_w33", w_out, mw[33]);
        rst = 1'b1;
        step();
        chk("t5_w_valid", {31'd0, w_valid}, 32'd0);
        chk("t5_w_out", w_out, 32'd0);
        chk("t5_w_idx", {26'd0, w_idx}, 32'd0);
        chk("t5_w_last", {31'd0, w_last}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_ready_low", {31'd0, start_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk("t5_ready_back", {31'd0, start_ready}, 32'd1);
        chk("t5_still_idle", {31'd0, w_valid}, 32'd0);

        // T6: ROUNDS=16 passes the block through unchanged
        blk16 = rnd_block();
        start_valid16 = 1'b1;
        step();
        start_valid16 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            chk("t6_valid", {31'd0, wv16}, 32'd1);
            chk("t6_w_out", wo16, blk16[511-32*t -: 32]);
            chk("t6_w_idx", {28'd0, wi16}, t);
            chk("t6_w_last", {31'd0, wl16}, {31'd0, t == 15});
            step();
        end
        chk("t6_done", {31'd0, done16}, 32'd1);
        chk("t6_valid_end", {31'd0, wv16}, 32'd0);
        step();
        chk("t6_done_once", {31'd0, done16}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
